gen_step_ctrl: RTL

//  Sequences one Game-of-Life generation over the 16x16 board. Paces steps in run mode and

---
 rtl/gen_step_ctrl_pkg.sv | 23 ++
 rtl/gen_step_ctrl_step_ticker.sv | 45 ++++
 rtl/gen_step_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gen_step_ctrl_pkg.sv
// Shared types and constants for the Game-of-Life generation sequencer.
// Used by gen_step_ctrl and step_ticker.
package gen_step_ctrl_pkg;

    localparam int BOARD_W_DEF = 16;
    localparam int CW          = $clog2(BOARD_W_DEF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_t;

    localparam logic MODE_EDIT = 1'b0;
    localparam logic MODE_RUN  = 1'b1;

    // Widened compare so non-power-of-two boards reject out-of-range cursors.
    function automatic logic in_board(input logic [CW-1:0] coord, input int board_w);
        return ({1'b0, coord} < (CW+1)'(board_w));
    endfunction

endpackage

// File: rtl/gen_step_ctrl_step_ticker.sv
// Run-mode step prescaler: a down-counter that pulses tick every (TICK_DIV >> speed)
// cycles, never faster than every 2 cycles. Held at 0 in edit mode.
module step_ticker
    import gen_step_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 1562500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [2:0] speed,
    output logic       tick
);

    localparam int TW = (TICK_DIV < 4) ? 2 : $clog2(TICK_DIV + 1);

    logic [TW-1:0] cnt;
    logic [TW-1:0] period_raw;
    logic [TW-1:0] reload;

    always_comb begin
        period_raw = TW'(TICK_DIV) >> speed;
        if (period_raw < TW'(2)) begin
            reload = TW'(1);
        end else begin
            reload = period_raw - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (mode == MODE_EDIT) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= reload;
        end else begin
            cnt <= cnt - TW'(1);
        end
    end

    // First run-mode cycle fires immediately because edit mode parks the counter at 0.
    assign tick = (mode == MODE_RUN) && (cnt == '0);

endmodule

// File: rtl/gen_step_ctrl.sv
// Generation sequencer: scans every board cell through the rule unit into the back bank,
// swaps banks, and arbitrates cursor toggles. Optional macro GEN_COUNTER_EN enables gen_count.
module gen_step_ctrl
    import gen_step_ctrl_pkg::*;
#(
    parameter int BOARD_W  = 16,
    parameter int TICK_DIV = 1562500
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic [2:0]    speed,
    input  logic          step_req,
    input  logic          toggle_req,
    input  logic [CW-1:0] cur_x,
    input  logic [CW-1:0] cur_y,
    output logic [CW-1:0] scan_x,
    output logic [CW-1:0] scan_y,
    output logic          wr_en,
    output logic [CW-1:0] wr_x,
    output logic [CW-1:0] wr_y,
    output logic          edit_we,
    output logic          bank,
    output logic          busy,
    output logic [15:0]   gen_count
);

    localparam logic [CW-1:0] LAST = CW'(BOARD_W - 1);

    state_t state;
    logic   pend;
    logic   tick;
    logic   start;
    logic   cur_ok;

    step_ticker #(.TICK_DIV(TICK_DIV)) u_ticker (
        .clk   (clk),
        .rst   (rst),
        .mode  (mode),
        .speed (speed),
        .tick  (tick)
    );

    assign start  = (state == IDLE) &&
                    (((mode == MODE_RUN) && (tick || pend)) ||
                     ((mode == MODE_EDIT) && step_req));
    assign cur_ok = in_board(cur_x, BOARD_W) && in_board(cur_y, BOARD_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            scan_x  <= '0;
            scan_y  <= '0;
            wr_en   <= 1'b0;
            wr_x    <= '0;
            wr_y    <= '0;
            edit_we <= 1'b0;
            bank    <= 1'b0;
            busy    <= 1'b0;
            pend    <= 1'b0;
        end else begin
            // Rule unit answers one cycle after the read address.
            wr_en   <= (state == SCAN);
            wr_x    <= scan_x;
            wr_y    <= scan_y;
            edit_we <= toggle_req && (mode == MODE_EDIT) && (state == IDLE) && !start && cur_ok;

            if (mode == MODE_EDIT || start) begin
                pend <= 1'b0;
            end else if (tick && state != IDLE) begin
                pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SCAN;
                        busy   <= 1'b1;
                        scan_x <= '0;
                        scan_y <= '0;
                    end
                end
                SCAN: begin
                    if (scan_x == LAST) begin
                        scan_x <= '0;
                        if (scan_y == LAST) begin
                            state  <= DRAIN;
                            scan_y <= '0;
                        end else begin
                            scan_y <= scan_y + CW'(1);
                        end
                    end else begin
                        scan_x <= scan_x + CW'(1);
                    end
                end
                DRAIN: state <= SWAP;
                SWAP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    bank  <= ~bank;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GEN_COUNTER_EN
    logic [15:0] gen_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_cnt <= '0;
        end else if (state == SWAP) begin
            gen_cnt <= gen_cnt + 16'd1;
        end
    end

    assign gen_count = gen_cnt;
`else
    assign gen_count = '0;
`endif

endmodule
